// File: rtl/touch_adc_reader.sv
// touch_adc_reader
//   SPI initiator for an AD7843-class touch-screen ADC. After penirq_n has
//   stayed low long enough, it repeatedly reads 12-bit X and Y while the pen
//   is held. It publishes clamped, scaled coordinates with a one-clock
//   enable strobe.
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high reset
//   penirq_n  pen interrupt from the ADC, low = touched (already synchronised)
//   adc_dout  ADC serial data out
//   adc_cs_n  ADC chip select, active low
//   adc_dclk  ADC serial clock (clk / (2*CLK_DIV))
//   adc_din   ADC serial data in (command byte, MSB first)
//   tor_x     X coordinate, raw_x[11:2] clamped to X_MAX
//   tor_y     Y coordinate, raw_y[11:3] clamped to Y_MAX
//   clcount   press phase: 0 none, 1 first sample, 2 held sample, 3 release
//   enable    one-clock strobe: tor_x/tor_y/clcount updated this cycle
module touch_adc_reader #(
  parameter int unsigned CLK_DIV      = 16,
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter int unsigned SAMPLE_GAP   = 250000,
  parameter logic [7:0]  CMD_X        = 8'hD0,
  parameter logic [7:0]  CMD_Y        = 8'h90,
  parameter logic [9:0]  X_MAX        = 10'd799,
  parameter logic [8:0]  Y_MAX        = 9'd479
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       penirq_n,
  input  logic       adc_dout,
  output logic       adc_cs_n,
  output logic       adc_dclk,
  output logic       adc_din,
  output logic [9:0] tor_x,
  output logic [8:0] tor_y,
  output logic [1:0] clcount,
  output logic       enable
);

  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_MAX = (DEBOUNCE_CYC > SAMPLE_GAP) ? DEBOUNCE_CYC : SAMPLE_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DEBOUNCE, S_CONV_X, S_CONV_Y, S_CHECK, S_PUBLISH, S_WAIT, S_RELEASE
  } state_t;

  state_t state_reg, state_next;

  // Frame timing. A frame is 50 half-periods of CLK_DIV clocks each:
  // halves 0..47 are the 24 DCLK periods (even = low, odd = high),
  // half 48 is the low tail with CS still asserted, and half 49 is CS high.
  logic [DIV_W-1:0] div_reg;
  logic [5:0]       half_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [11:0] shift_reg;
  logic [11:0] raw_x_reg;
  logic [11:0] raw_y_reg;
  logic        published_reg;

  logic in_frame;
  logic frame_last;
  logic rise_edge;
  logic data_rise;
  logic sample_valid;
  logic [7:0] cmd_sel;

  logic cs_n_next;
  logic dclk_next;
  logic din_next;
  logic pub_strobe;
  logic rel_strobe;

  logic [9:0] sx;
  logic [8:0] sy;
  logic [9:0] tor_x_next;
  logic [8:0] tor_y_next;

  assign in_frame   = (state_reg == S_CONV_X) || (state_reg == S_CONV_Y);
  assign frame_last = in_frame && (half_reg == 6'd49) && (div_reg == DIV_W'(CLK_DIV - 1));
  assign cmd_sel    = (state_reg == S_CONV_X) ? CMD_X : CMD_Y;

  // Output registers lag the counters by one clock. The edge that leaves
  // the first clock of an odd half is therefore the edge on which adc_dclk
  // goes 0->1. adc_dout is captured on that same edge.
  assign rise_edge = in_frame && half_reg[0] && (half_reg < 6'd48) && (div_reg == '0);
  // Rise index = half_reg[5:1]. Rises 9..20 carry raw[11:0], MSB first.
  assign data_rise = rise_edge && (half_reg[5:1] >= 5'd9) && (half_reg[5:1] <= 5'd20);

  assign sample_valid = (raw_x_reg != 12'h000) && (raw_x_reg != 12'hFFF) &&
                        (raw_y_reg != 12'h000) && (raw_y_reg != 12'hFFF);

  assign sx         = raw_x_reg[11:2];
  assign sy         = raw_y_reg[11:3];
  assign tor_x_next = (sx > X_MAX) ? X_MAX : sx;
  assign tor_y_next = (sy > Y_MAX) ? Y_MAX : sy;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. penirq_n is not examined during the conversions,
  // because the ADC disturbs it while converting.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:     if (!penirq_n) state_next = S_DEBOUNCE;
      S_DEBOUNCE: begin
        if (penirq_n) begin
          state_next = S_IDLE;
        end else if (cnt_reg == CNT_W'(DEBOUNCE_CYC - 1)) begin
          state_next = S_CONV_X;
        end
      end
      S_CONV_X:   if (frame_last) state_next = S_CONV_Y;
      S_CONV_Y:   if (frame_last) state_next = S_CHECK;
      S_CHECK:    state_next = sample_valid ? S_PUBLISH : S_WAIT;
      S_PUBLISH:  state_next = S_WAIT;
      S_WAIT: begin
        if (cnt_reg == CNT_W'(SAMPLE_GAP - 1)) begin
          state_next = penirq_n ? S_RELEASE : S_CONV_X;
        end
      end
      S_RELEASE:  state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Output decode from the current state and counters. It is registered
  // below, so the pins stay glitch-free.
  always_comb begin
    cs_n_next  = 1'b1;
    dclk_next  = 1'b0;
    din_next   = 1'b0;
    pub_strobe = 1'b0;
    rel_strobe = 1'b0;
    if (in_frame) begin
      cs_n_next = (half_reg >= 6'd49);
      if (half_reg < 6'd48) begin
        dclk_next = half_reg[0];
      end
      // Command bit k is held across both halves of DCLK period k. It can
      // therefore change only on the edge where DCLK returns low.
      if (half_reg[5:4] == 2'b00) begin
        din_next = cmd_sel[3'd7 - half_reg[3:1]];
      end
    end
    if (state_reg == S_PUBLISH) pub_strobe = 1'b1;
    if ((state_reg == S_RELEASE) && published_reg) rel_strobe = 1'b1;
  end

  // Counters and sample datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg       <= '0;
      half_reg      <= '0;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      raw_x_reg     <= '0;
      raw_y_reg     <= '0;
      published_reg <= 1'b0;
    end else begin
      if (!in_frame || frame_last) begin
        div_reg  <= '0;
        half_reg <= '0;
      end else if (div_reg == DIV_W'(CLK_DIV - 1)) begin
        div_reg  <= '0;
        half_reg <= half_reg + 6'd1;
      end else begin
        div_reg <= div_reg + DIV_W'(1);
      end

      // One counter serves both the debounce and the inter-sample gap. It
      // restarts whenever the state changes, so a pen bounce in DEBOUNCE
      // (which returns to IDLE) always starts the count afresh.
      if (((state_reg == S_DEBOUNCE) || (state_reg == S_WAIT)) && (state_next == state_reg)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end else begin
        cnt_reg <= '0;
      end

      // Exactly 12 bits are shifted per frame, so the register needs no
      // clearing between frames.
      if (data_rise) begin
        shift_reg <= {shift_reg[10:0], adc_dout};
      end
      if (frame_last && (state_reg == S_CONV_X)) raw_x_reg <= shift_reg;
      if (frame_last && (state_reg == S_CONV_Y)) raw_y_reg <= shift_reg;

      if (state_reg == S_IDLE) begin
        published_reg <= 1'b0;
      end else if (state_reg == S_PUBLISH) begin
        published_reg <= 1'b1;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      adc_cs_n <= 1'b1;
      adc_dclk <= 1'b0;
      adc_din  <= 1'b0;
      tor_x    <= '0;
      tor_y    <= '0;
      clcount  <= '0;
      enable   <= 1'b0;
    end else begin
      adc_cs_n <= cs_n_next;
      adc_dclk <= dclk_next;
      adc_din  <= din_next;
      enable   <= pub_strobe || rel_strobe;
      if (pub_strobe) begin
        tor_x   <= tor_x_next;
        tor_y   <= tor_y_next;
        clcount <= published_reg ? 2'd2 : 2'd1;
      end else if (rel_strobe) begin
        clcount <= 2'd3;
      end else if (enable && (clcount == 2'd3)) begin
        // The release tag lasts only for its strobe cycle.
        clcount <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_touch_adc_reader.sv
// Testbench for touch_adc_reader. It contains a behavioural ADC model that
// decodes the command byte and returns the programmed X/Y words. It also
// contains an SPI waveform monitor and a table of press scenarios.
module tb_touch_adc_reader;

  localparam int CLK_DIV = 2;
  localparam int DEB     = 8;
  localparam int GAP     = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       penirq_n = 1'b1;
  logic       adc_dout = 1'b0;
  logic       adc_cs_n;
  logic       adc_dclk;
  logic       adc_din;
  logic [9:0] tor_x;
  logic [8:0] tor_y;
  logic [1:0] clcount;
  logic       enable;

  always #5 clk = ~clk;

  touch_adc_reader #(
    .CLK_DIV(CLK_DIV),
    .DEBOUNCE_CYC(DEB),
    .SAMPLE_GAP(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .penirq_n(penirq_n),
    .adc_dout(adc_dout),
    .adc_cs_n(adc_cs_n),
    .adc_dclk(adc_dclk),
    .adc_din(adc_din),
    .tor_x(tor_x),
    .tor_y(tor_y),
    .clcount(clcount),
    .enable(enable)
  );

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    bit          pub;
    bit          hold;
    int          ex;
    int          ey;
  } vec_t;

  int checks = 0;
  int fails  = 0;

  // ADC model and monitor state
  logic [11:0] xval = 12'h000;
  logic [11:0] yval = 12'h000;
  logic        prev_cs = 1'b1;
  logic        prev_dclk = 1'b0;
  logic        prev_din = 1'b0;
  int          rises = 0;
  int          cyc = 0;
  int          last_rise_cyc = 0;
  logic [7:0]  cmd_sh = 8'h00;
  logic [7:0]  exp_cmd = 8'hD0;
  int          cs_falls = 0;
  int          ev_cnt = 0;
  bit          rel_chk = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Advance to the next falling edge. Then run the monitor and drive the
  // ADC data line for the next DCLK rise.
  task automatic tick();
    logic [11:0] word;
    @(negedge clk);
    cyc++;
    if (reset) begin
      rises   = 0;
      cmd_sh  = 8'h00;
      exp_cmd = 8'hD0;
      rel_chk = 1'b0;
      adc_dout = 1'b0;
    end else begin
      if (rel_chk) begin
        chk("clcount_zero_after_release", int'(clcount), 0);
        rel_chk = 1'b0;
      end
      if (enable) begin
        ev_cnt++;
        $display("strobe: tor_x=%0d tor_y=%0d clcount=%0d", tor_x, tor_y, clcount);
        if (clcount == 2'd3) rel_chk = 1'b1;
      end
      if (prev_cs && !adc_cs_n) begin
        cs_falls++;
        rises  = 0;
        cmd_sh = 8'h00;
      end
      if (!adc_cs_n && adc_dclk) begin
        chk("din_stable_while_dclk_high", int'(adc_din), int'(prev_din));
      end
      if (!adc_cs_n && !prev_dclk && adc_dclk) begin
        if (rises > 0) chk("dclk_period", cyc - last_rise_cyc, 2 * CLK_DIV);
        last_rise_cyc = cyc;
        if (rises < 8) cmd_sh = {cmd_sh[6:0], adc_din};
        rises++;
      end
      if (!prev_cs && adc_cs_n) begin
        chk("dclk_rises_per_frame", rises, 24);
        chk("command_byte", int'(cmd_sh), int'(exp_cmd));
        chk("din_low_when_deselected", int'(adc_din), 0);
        $display("frame: cmd=%02h rises=%0d", cmd_sh, rises);
        exp_cmd = (exp_cmd == 8'hD0) ? 8'h90 : 8'hD0;
      end
      if (!adc_cs_n && rises >= 9 && rises <= 20) begin
        word = (cmd_sh == 8'hD0) ? xval : yval;
        adc_dout = word[20 - rises];
      end else begin
        adc_dout = 1'b0;
      end
    end
    prev_cs   = adc_cs_n;
    prev_dclk = adc_dclk;
    prev_din  = adc_din;
  endtask

  task automatic wait_ev(input int bound, output bit got);
    int start;
    start = ev_cnt;
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      tick();
      if (ev_cnt != start) got = 1'b1;
    end
  endtask

  initial begin
    vec_t vecs [0:6];
    bit   got;
    int   start;
    int   falls0;
    int   last_x;
    int   last_y;
    int   pulses [0:1];

    vecs[0] = '{x: 12'h640, y: 12'h3C0, pub: 1'b1, hold: 1'b1, ex: 400, ey: 120};
    vecs[1] = '{x: 12'hFFC, y: 12'hFF8, pub: 1'b1, hold: 1'b0, ex: 799, ey: 479};
    vecs[2] = '{x: 12'h640, y: 12'h000, pub: 1'b0, hold: 1'b0, ex: 0,   ey: 0};
    vecs[3] = '{x: 12'hFFF, y: 12'h3C0, pub: 1'b0, hold: 1'b0, ex: 0,   ey: 0};
    vecs[4] = '{x: 12'h001, y: 12'hFFE, pub: 1'b1, hold: 1'b0, ex: 0,   ey: 479};
    vecs[5] = '{x: 12'hC80, y: 12'hF00, pub: 1'b1, hold: 1'b1, ex: 799, ey: 479};
    vecs[6] = '{x: 12'hC7F, y: 12'hEF7, pub: 1'b1, hold: 1'b0, ex: 799, ey: 478};
    pulses[0] = 5;
    pulses[1] = 7;

    // Reset state
    repeat (3) tick();
    chk("reset_cs_n", int'(adc_cs_n), 1);
    chk("reset_dclk", int'(adc_dclk), 0);
    chk("reset_din", int'(adc_din), 0);
    chk("reset_tor_x", int'(tor_x), 0);
    chk("reset_tor_y", int'(tor_y), 0);
    chk("reset_clcount", int'(clcount), 0);
    chk("reset_enable", int'(enable), 0);
    reset = 1'b0;
    repeat (3) tick();

    // Short pen pulses must not start a conversion.
    for (int p = 0; p < 2; p++) begin
      falls0 = cs_falls;
      penirq_n = 1'b0;
      repeat (pulses[p]) tick();
      penirq_n = 1'b1;
      repeat (50) tick();
      chk("short_pulse_no_frame", cs_falls - falls0, 0);
      $display("pulse of %0d clks: frames started=%0d", pulses[p], cs_falls - falls0);
    end

    // A held pen starts a frame shortly after the debounce period. All-zero
    // data is invalid, so no strobe follows.
    xval = 12'h000;
    yval = 12'h000;
    falls0 = cs_falls;
    start = ev_cnt;
    penirq_n = 1'b0;
    for (int i = 0; i < DEB + 6 && cs_falls == falls0; i++) tick();
    chk("frame_after_debounce", cs_falls - falls0, 1);
    penirq_n = 1'b1;
    repeat (400) tick();
    chk("zero_data_no_strobe", ev_cnt - start, 0);

    // Table-driven press scenarios
    last_x = 0;
    last_y = 0;
    for (int v = 0; v < 7; v++) begin
      xval = vecs[v].x;
      yval = vecs[v].y;
      penirq_n = 1'b0;
      if (vecs[v].pub) begin
        wait_ev(400, got);
        chk($sformatf("v%0d_first_strobe_seen", v), int'(got), 1);
        chk($sformatf("v%0d_tor_x", v), int'(tor_x), vecs[v].ex);
        chk($sformatf("v%0d_tor_y", v), int'(tor_y), vecs[v].ey);
        chk($sformatf("v%0d_clcount_first", v), int'(clcount), 1);
        if (vecs[v].hold) begin
          tick();
          chk($sformatf("v%0d_enable_one_clk", v), int'(enable), 0);
          wait_ev(400, got);
          chk($sformatf("v%0d_held_strobe_seen", v), int'(got), 1);
          chk($sformatf("v%0d_held_clcount", v), int'(clcount), 2);
          chk($sformatf("v%0d_held_tor_x", v), int'(tor_x), vecs[v].ex);
          chk($sformatf("v%0d_held_tor_y", v), int'(tor_y), vecs[v].ey);
        end
        penirq_n = 1'b1;
        wait_ev(400, got);
        chk($sformatf("v%0d_release_strobe_seen", v), int'(got), 1);
        chk($sformatf("v%0d_release_clcount", v), int'(clcount), 3);
        chk($sformatf("v%0d_release_tor_x", v), int'(tor_x), vecs[v].ex);
        chk($sformatf("v%0d_release_tor_y", v), int'(tor_y), vecs[v].ey);
        repeat (5) tick();
        last_x = vecs[v].ex;
        last_y = vecs[v].ey;
      end else begin
        start = ev_cnt;
        repeat (400) tick();
        chk($sformatf("v%0d_invalid_no_strobe", v), ev_cnt - start, 0);
        penirq_n = 1'b1;
        repeat (400) tick();
        chk($sformatf("v%0d_no_release_strobe", v), ev_cnt - start, 0);
        chk($sformatf("v%0d_tor_x_held", v), int'(tor_x), last_x);
        chk($sformatf("v%0d_tor_y_held", v), int'(tor_y), last_y);
      end
      $display("vector %0d: x=%03h y=%03h tor_x=%0d tor_y=%0d", v, vecs[v].x, vecs[v].y, tor_x, tor_y);
    end

    // Reset in the middle of an X frame
    xval = 12'h640;
    yval = 12'h3C0;
    penirq_n = 1'b0;
    for (int i = 0; i < DEB + 6 && adc_cs_n; i++) tick();
    chk("midframe_cs_low_before_reset", int'(adc_cs_n), 0);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    chk("midframe_reset_cs_n", int'(adc_cs_n), 1);
    chk("midframe_reset_dclk", int'(adc_dclk), 0);
    chk("midframe_reset_enable", int'(enable), 0);
    chk("midframe_reset_tor_x", int'(tor_x), 0);
    chk("midframe_reset_tor_y", int'(tor_y), 0);
    chk("midframe_reset_clcount", int'(clcount), 0);
    reset = 1'b0;
    penirq_n = 1'b1;
    start = ev_cnt;
    falls0 = cs_falls;
    repeat (300) tick();
    chk("after_reset_no_strobe", ev_cnt - start, 0);
    chk("after_reset_idle", cs_falls - falls0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
